// File: rtl/score_pkg.sv
// Shared constants, FSM state type and slot geometry for the score display.
package score_pkg;

    localparam int NUM_DIGITS   = 5;
    localparam int SCORE_W      = 17;
    localparam int BCD_W        = 20;
    localparam int SCORE_MAX    = 99999;
    localparam int ROW_TOP      = 70;
    localparam int ROW_BOT      = 110;
    localparam int DIGIT_W      = 25;
    localparam int FIRST_OFFSET = 20;
    localparam int DIGIT_PITCH  = 26;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        HOLD    = 2'd2
    } state_e;

    // Left edge (exclusive) of slot k; slot 0 holds the most significant digit.
    function automatic logic [9:0] slot_offset(input int first, input int pitch, input int k);
        return 10'(first + k * pitch);
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble: one add-3/shift step per cycle, SCORE_W steps per start.
module bin2bcd_serial #(
    parameter int SCORE_W = 17,
    parameter int BCD_W   = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [SCORE_W-1:0] bin_in,
    output logic               done,
    output logic [BCD_W-1:0]   bcd_out
);

    localparam int CNT_W = $clog2(SCORE_W + 1);

    logic [SCORE_W-1:0] sh_q, sh_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj, bcd_step;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
        bcd_step = {bcd_adj[BCD_W-2:0], sh_q[SCORE_W-1]};

        sh_d  = sh_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        if (start) begin
            sh_d  = bin_in;
            bcd_d = '0;
            cnt_d = CNT_W'(SCORE_W);
        end else if (cnt_q != '0) begin
            sh_d  = sh_q << 1;
            bcd_d = bcd_step;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // done flags the final step; bcd_out is that step's result, valid alongside done.
    assign done    = (cnt_q == CNT_W'(1)) && !start;
    assign bcd_out = bcd_step;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q  <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/score_display_ctrl.sv
// Score display controller: clamps and converts a binary score to BCD,
// commits it on vertical blank, and looks up the digit under the current pixel.
module score_display_ctrl #(
    parameter int NUM_DIGITS   = score_pkg::NUM_DIGITS,
    parameter int SCORE_W      = score_pkg::SCORE_W,
    parameter int FIRST_OFFSET = score_pkg::FIRST_OFFSET,
    parameter int DIGIT_PITCH  = score_pkg::DIGIT_PITCH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SCORE_W-1:0] score_in,
    input  logic               score_valid,
    output logic               score_ready,
    input  logic               frame_start,
    input  logic [9:0]         col,
    input  logic [9:0]         row,
    output logic               busy,
    output logic               digit_valid,
    output logic [6:0]         digit_offset,
    output logic [3:0]         digit_value
);

    import score_pkg::*;

    localparam int DISP_W = 4 * NUM_DIGITS;

    state_e              state_q;
    logic [DISP_W-1:0]   pend_q, disp_q, conv_bcd;
    logic [SCORE_W-1:0]  score_clamped;
    logic                accept, conv_done;

    logic                vld_q, vld_d;
    logic [6:0]          off_q, off_d;
    logic [3:0]          val_q, val_d;
    logic [9:0]          lo;
    logic                row_in;

    assign score_ready   = (state_q != CONVERT);
    assign busy          = (state_q == CONVERT);
    assign accept        = score_valid && score_ready;
    assign score_clamped = (32'(score_in) > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : score_in;

    bin2bcd_serial #(
        .SCORE_W (SCORE_W),
        .BCD_W   (DISP_W)
    ) u_conv (
        .clk     (clk),
        .reset   (reset),
        .start   (accept),
        .bin_in  (score_clamped),
        .done    (conv_done),
        .bcd_out (conv_bcd)
    );

    // In HOLD, a coincident frame_start commits the old pending before the new score converts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            disp_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) state_q <= CONVERT;
                end
                CONVERT: begin
                    if (conv_done) begin
                        pend_q  <= conv_bcd;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (frame_start) begin
                        disp_q  <= pend_q;
                        state_q <= IDLE;
                    end
                    if (accept) state_q <= CONVERT;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Slots never overlap, so the first hit found is the only one.
    always_comb begin
        vld_d  = 1'b0;
        off_d  = '0;
        val_d  = '0;
        lo     = '0;
        row_in = (row > 10'(ROW_TOP)) && (row <= 10'(ROW_BOT));
        for (int k = 0; k < NUM_DIGITS; k++) begin
            lo = slot_offset(FIRST_OFFSET, DIGIT_PITCH, k);
            if (!vld_d && row_in && (col > lo) && (col <= lo + 10'(DIGIT_W))) begin
                vld_d = 1'b1;
                off_d = lo[6:0];
                val_d = disp_q[(NUM_DIGITS-1-k)*4 +: 4];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= 1'b0;
            off_q <= '0;
            val_q <= '0;
        end else begin
            vld_q <= vld_d;
            off_q <= off_d;
            val_q <= val_d;
        end
    end

    assign digit_valid  = vld_q;
    assign digit_offset = off_q;
    assign digit_value  = val_q;

endmodule
